// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: one result bit per cycle on operand magnitudes,
// followed by a finishing cycle that applies the sign and detects overflow / divide-by-zero.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_r;
   logic [CW-1:0]        cnt_r;
   logic                 last_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     opb_r;
   logic                 neg_r;
   logic                 divz_r;
   logic [WIDTH-1:0]     result_r;
   logic                 exc_r;
   logic                 rdy_r;
   logic                 busy_r;

   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH-1:0]   mul_next_s;
   logic [WIDTH:0]       rem_sh_s;
   logic [WIDTH:0]       trial_s;
   logic [2*WIDTH-1:0]   div_next_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH:0]       prod_top_s;
   logic                 mul_ovf_s;
   logic [WIDTH-1:0]     quo_s;
   logic                 div_exc_s;

   // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      if (x[WIDTH-1]) begin
         r = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = x;
      end
      return r;
   endfunction

   // Datapath for one shift-add / restoring-divide step and for the sign-fix finishing cycle.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                 + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

      rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      trial_s    = rem_sh_s - {1'b0, opb_r};
      if (trial_s[WIDTH]) begin
         div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
         div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end

      prod_s     = neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
      prod_top_s = prod_s[2*WIDTH-1:WIDTH-1];
      mul_ovf_s  = (|prod_top_s) & ~(&prod_top_s);

      // A positive quotient of 2^(WIDTH-1) only arises from min / -1 and is not representable.
      quo_s      = neg_r ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_r[WIDTH-1:0];
      div_exc_s  = divz_r | (~neg_r & acc_r[WIDTH-1]);
   end

   // Control FSM with registered result, flag, ready pulse and busy.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         last_r   <= 1'b0;
         acc_r    <= {(2*WIDTH){1'b0}};
         opb_r    <= {WIDTH{1'b0}};
         neg_r    <= 1'b0;
         divz_r   <= 1'b0;
         result_r <= {WIDTH{1'b0}};
         exc_r    <= 1'b0;
         rdy_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               rdy_r <= 1'b0;
               if (ctrl_MULT ^ ctrl_DIV) begin
                  acc_r   <= {{WIDTH{1'b0}}, abs_val(data_operandA)};
                  opb_r   <= abs_val(data_operandB);
                  neg_r   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  divz_r  <= (data_operandB == {WIDTH{1'b0}});
                  cnt_r   <= {CW{1'b0}};
                  last_r  <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ctrl_MULT ? MULT : DIV;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            MULT, DIV: begin
               if (last_r) begin
                  if (state_r == MULT) begin
                     result_r <= prod_s[WIDTH-1:0];
                     exc_r    <= mul_ovf_s;
                  end else begin
                     result_r <= divz_r ? {WIDTH{1'b0}} : quo_s;
                     exc_r    <= div_exc_s;
                  end
                  rdy_r   <= 1'b1;
                  last_r  <= 1'b0;
                  state_r <= DONE;
               end else begin
                  acc_r  <= (state_r == MULT) ? mul_next_s : div_next_s;
                  cnt_r  <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
                  last_r <= (cnt_r == CNT_LAST);
               end
            end
            DONE: begin
               rdy_r   <= 1'b0;
               busy_r  <= 1'b0;
               cnt_r   <= {CW{1'b0}};
               last_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               rdy_r   <= 1'b0;
               busy_r  <= 1'b0;
               cnt_r   <= {CW{1'b0}};
               last_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign data_result    = result_r;
   assign data_exception = exc_r;
   assign data_resultRDY = rdy_r;
   assign busy           = busy_r;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port clr_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_operandA  input  WIDTH  signed two's-complement multiplicand/dividend.
REQ-005 SHALL have port data_operandB  input  WIDTH  signed two's-complement multiplier/divisor.
REQ-006 SHALL have port ctrl_MULT  input  1  start-multiply request, sampled on clk.
REQ-007 SHALL have port ctrl_DIV  input  1  start-divide request, sampled on clk.
REQ-008 SHALL have port data_result  output  WIDTH  result, feeds register-file write data.
REQ-009 SHALL have port data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle result-valid pulse, feeds register write enable.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-012 SHALL implement the FSM states IDLE, MULT, DIV and DONE.
REQ-013 In IDLE, an edge with exactly one of ctrl_MULT/ctrl_DIV high SHALL latch both operands and go to MULT or DIV respectively.
REQ-014 In IDLE, an edge with both ctrl_MULT and ctrl_DIV high SHALL be ignored; the FSM stays in IDLE and outputs are unchanged.
REQ-015 ctrl_MULT/ctrl_DIV SHALL be ignored outside IDLE; operand changes after the start edge SHALL NOT affect the result.
REQ-016 MULT and DIV SHALL each iterate exactly WIDTH cycles (one bit per cycle, iteration counter 0..WIDTH-1), then go to DONE.
REQ-017 DONE SHALL last one cycle, then return to IDLE; ctrl inputs are ignored in DONE.
REQ-018 Latency: start sampled at edge k -> data_resultRDY=1 only in the cycle after edge k+WIDTH+1, for exactly one cycle.
REQ-019 busy SHALL be 1 from the cycle after the start edge through the DONE cycle, and 0 otherwise.
REQ-020 Multiply: data_result SHALL be the low WIDTH bits of the exact signed product A*B.
REQ-021 Multiply: data_exception SHALL be 1 iff the exact signed product is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-022 Divide: data_result SHALL be the signed quotient truncated toward zero; the remainder is discarded.
REQ-023 Divide by zero (B=0): data_result=0, data_exception=1, with the same latency as REQ-018.
REQ-024 Divide with A=-2^(WIDTH-1) and B=-1: data_result=A (0x80000000 at WIDTH=32), data_exception=1.
REQ-025 data_result and data_exception SHALL update only when DONE is entered and SHALL hold until the next DONE.
REQ-026 Back-to-back operation: a start accepted in the first IDLE cycle after DONE SHALL behave identically to an isolated start.

Reset
REQ-027 clr_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and the iteration counter to 0.
REQ-028 clr_n=0 SHALL force data_result=0, data_exception=0, data_resultRDY=0 and busy=0.
REQ-029 Reset during MULT/DIV/DONE SHALL abort the operation; no data_resultRDY pulse occurs for it.
REQ-030 The first edge with clr_n=1 SHALL be able to accept a start request.

Verification
REQ-031 MULT A=7, B=-6 (0xFFFFFFFA) -> after 33 cycles RDY pulse, result 0xFFFFFFD6, exception 0.
REQ-032 MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; A=0xFFFFFFFF, B=0xFFFFFFFF -> result 1, exception 0.
REQ-033 DIV A=-7, B=2 -> result 0xFFFFFFFD; DIV A=5, B=0 -> result 0, exception 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, exception 1.
REQ-034 Start MULT, pulse ctrl_DIV and change operands at cycle 10 -> MULT result unaffected; RDY at cycle 33 only.
REQ-035 Start DIV, drop clr_n at cycle 15 -> all outputs 0 immediately, no RDY; a new MULT 3*4 after release -> result 12.
REQ-036 ctrl_MULT and ctrl_DIV both high in IDLE -> busy stays 0, no RDY within 40 cycles.
